// File: rtl/axi_write_master_pkg.sv
// rtl/axi_write_master_pkg.sv - shared types and AXI constants for the write master
package axi_write_master_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} WrState_t;

    typedef logic [1:0] AxiBurst_t;
    typedef logic [1:0] AxiResp_t;

    localparam AxiBurst_t AXI_BURST_INCR  = 2'b01;
    localparam AxiResp_t  AXI_RESP_OKAY   = 2'b00;
    localparam AxiResp_t  AXI_RESP_SLVERR = 2'b10;
    localparam AxiResp_t  AXI_RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input AxiResp_t resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_write_master_if.sv
// rtl/axi_write_master_if.sv - core store-write port plus AXI AW/W/B channels
interface axi_write_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import axi_write_master_pkg::*;

    logic                  initWrite;
    logic [ADDR_W-1:0]     writeAddr;
    logic [7:0]            writeLen;
    logic                  writeReady;
    logic                  wDataValid;
    logic [DATA_W-1:0]     wData;
    logic [DATA_W/8-1:0]   mask;
    logic                  wDataNext;
    logic                  wDone;
    logic                  wErr;

    logic                  m_awvalid;
    logic                  m_awready;
    logic [ADDR_W-1:0]     m_awaddr;
    logic [7:0]            m_awlen;
    logic [2:0]            m_awsize;
    AxiBurst_t             m_awburst;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_wlast;
    logic                  m_bvalid;
    logic                  m_bready;
    AxiResp_t              m_bresp;

    modport master (
        input  initWrite, writeAddr, writeLen, wDataValid, wData, mask,
               m_awready, m_wready, m_bvalid, m_bresp,
        output writeReady, wDataNext, wDone, wErr,
               m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
               m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
    );

    modport slave (
        output initWrite, writeAddr, writeLen, wDataValid, wData, mask,
               m_awready, m_wready, m_bvalid, m_bresp,
        input  writeReady, wDataNext, wDone, wErr,
               m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
               m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
    );

endinterface

// File: rtl/axi_write_master_wr_beat_fifo.sv
// rtl/axi_write_master_wr_beat_fifo.sv - small synchronous FIFO of {data, strb} beats
module wr_beat_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/axi_write_master.sv
// rtl/axi_write_master.sv - turns one core write request into one AXI4 INCR burst
module axi_write_master
    import axi_write_master_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    axi_write_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int FW     = DATA_W + STRB_W;

    WrState_t          state;
    WrState_t          state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [8:0]        accept_cnt;
    logic [8:0]        issue_cnt;
    logic              done_q;
    logic              err_q;
    logic              accepting;
    logic              push;
    logic              pop;
    logic              last_beat;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accepting = 1'b0;
        unique case (state)
            IDLE: if (bus.initWrite) state_nxt = ADDR;
            ADDR: begin
                accepting = 1'b1;
                if (bus.m_awready) state_nxt = DATA;
            end
            DATA: begin
                accepting = 1'b1;
                if (pop && last_beat) state_nxt = RESP;
            end
            RESP: if (bus.m_bvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beats may be buffered while AW is still pending, but never more than len+1
    assign push      = accepting && bus.wDataValid && !fifo_full && (accept_cnt <= {1'b0, len_q});
    assign pop       = (state == DATA) && !fifo_empty && bus.m_wready;
    assign last_beat = (issue_cnt == {1'b0, len_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            accept_cnt <= '0;
            issue_cnt  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state == IDLE && bus.initWrite) begin
                addr_q     <= bus.writeAddr & ~ADDR_W'(3);
                len_q      <= bus.writeLen;
                accept_cnt <= '0;
                issue_cnt  <= '0;
            end else begin
                if (push) accept_cnt <= accept_cnt + 9'd1;
                if (pop)  issue_cnt  <= issue_cnt + 9'd1;
            end
            done_q <= (state == RESP) && bus.m_bvalid;
            err_q  <= (state == RESP) && bus.m_bvalid && resp_is_err(bus.m_bresp);
        end
    end

    wr_beat_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .data  ({bus.wData, bus.mask}),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.writeReady = (state == IDLE);
    assign bus.wDataNext  = push;
    assign bus.wDone      = done_q;
    assign bus.wErr       = err_q;
    assign bus.m_awvalid  = (state == ADDR);
    assign bus.m_awaddr   = addr_q;
    assign bus.m_awlen    = len_q;
    assign bus.m_awsize   = 3'($clog2(STRB_W));
    assign bus.m_awburst  = AXI_BURST_INCR;
    assign bus.m_wvalid   = (state == DATA) && !fifo_empty;
    assign bus.m_wdata    = head[FW-1:STRB_W];
    assign bus.m_wstrb    = head[STRB_W-1:0];
    assign bus.m_wlast    = last_beat;
    assign bus.m_bready   = (state == RESP);

endmodule

// File: tb/tb_axi_write_master.sv
// tb/tb_axi_write_master.sv - scoreboard bench for axi_write_master
module tb_axi_write_master;

    logic clk;
    logic rst;
    int   cyc;

    axi_write_master_if #(.ADDR_W(32), .DATA_W(32)) bus();

    axi_write_master #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_tests;
    int n_fail;

    logic [39:0] aw_q[$];
    logic [36:0] w_q[$];
    logic        done_q[$];
    logic [35:0] beat_q[$];

    int   next_cnt;
    int   done_cnt;
    int   done_cyc;
    int   init_cyc;
    logic took;
    int   w_mode;
    logic aw_rdy;
    logic [1:0] b_resp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (took && beat_q.size() > 0) void'(beat_q.pop_front());
        took = 1'b0;
        bus.wDataValid = (beat_q.size() > 0);
        if (beat_q.size() > 0) begin
            bus.wData = beat_q[0][35:4];
            bus.mask  = beat_q[0][3:0];
        end
        if (w_mode == 1) bus.m_wready = ~bus.m_wready;
        else             bus.m_wready = (w_mode == 0);
        bus.m_awready = aw_rdy;
        bus.m_bresp   = b_resp;
    end

    always @(negedge clk) begin
        logic [39:0] ea;
        logic [36:0] ew;
        logic        ed;
        if (!rst) begin
            if (bus.wDataNext) begin
                next_cnt++;
                took = 1'b1;
            end
            if (bus.m_awvalid && bus.m_awready) begin
                if (aw_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL aw_unexpected actual=%0h required=none", bus.m_awaddr);
                end else begin
                    ea = aw_q.pop_front();
                    check("aw_addr", 64'(bus.m_awaddr), 64'(ea[39:8]));
                    check("aw_len", 64'(bus.m_awlen), 64'(ea[7:0]));
                end
            end
            if (bus.m_wvalid && bus.m_wready) begin
                if (w_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL w_unexpected actual=%0h required=none", bus.m_wdata);
                end else begin
                    ew = w_q.pop_front();
                    check("w_data", 64'(bus.m_wdata), 64'(ew[36:5]));
                    check("w_strb", 64'(bus.m_wstrb), 64'(ew[4:1]));
                    check("w_last", 64'(bus.m_wlast), 64'(ew[0]));
                end
            end
            if (bus.wDone) begin
                done_cnt++;
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    ed = done_q.pop_front();
                    check("done_err", 64'(bus.wErr), 64'(ed));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic add_beat(input logic [31:0] d, input logic [3:0] m, input logic last);
        beat_q.push_back({d, m});
        w_q.push_back({d, m, last});
    endtask

    task automatic do_init(input logic [31:0] a, input logic [7:0] l);
        assert (((a & 32'hFFF) + (32'(l) + 1) * 4) <= 32'd4096) else $error("stimulus crosses 4KB");
        aw_q.push_back({a & 32'hFFFF_FFFC, l});
        bus.initWrite = 1'b1;
        bus.writeAddr = a;
        bus.writeLen  = l;
        init_cyc = cyc;
        @(posedge clk);
        #1;
        bus.initWrite = 1'b0;
    endtask

    task automatic wait_done(input int target, input string nm);
        for (int i = 0; i < 200 && done_cnt < target; i++) tick();
        check(nm, 64'(done_cnt), 64'(target));
    endtask

    int base;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        next_cnt = 0; done_cnt = 0; done_cyc = 0; init_cyc = 0; took = 1'b0;
        w_mode = 0; aw_rdy = 1'b1; b_resp = 2'b00;
        rst = 1'b1;
        bus.initWrite = 1'b0; bus.writeAddr = '0; bus.writeLen = '0;
        bus.wDataValid = 1'b0; bus.wData = '0; bus.mask = '0;
        bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_writeReady", 64'(bus.writeReady), 1);
        check("rst_awvalid", 64'(bus.m_awvalid), 0);
        check("rst_wvalid", 64'(bus.m_wvalid), 0);
        check("rst_bready", 64'(bus.m_bready), 0);
        check("rst_wDone", 64'(bus.wDone), 0);
        check("rst_wDataNext", 64'(bus.wDataNext), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single beat, minimum latency
        add_beat(32'hDEADBEEF, 4'hF, 1'b1);
        done_q.push_back(1'b0);
        do_init(32'h0000_1004, 8'd0);
        check("awsize", 64'(bus.m_awsize), 2);
        check("awburst", 64'(bus.m_awburst), 1);
        wait_done(1, "t1_done");
        check("t1_latency", 64'(done_cyc - init_cyc), 4);

        // four beats with wready toggling
        w_mode = 1;
        base = next_cnt;
        for (int i = 0; i < 4; i++) add_beat(32'(i), 4'hF, i == 3);
        done_q.push_back(1'b0);
        do_init(32'h0000_2000, 8'd3);
        wait_done(2, "t2_done");
        check("t2_next_pulses", 64'(next_cnt - base), 4);
        w_mode = 0;

        // AW stall for 10 cycles
        aw_rdy = 1'b0;
        @(posedge clk); #1;
        base = next_cnt;
        add_beat(32'h0000_0030, 4'h1, 1'b0);
        add_beat(32'h0000_0031, 4'h2, 1'b0);
        add_beat(32'h0000_0032, 4'h4, 1'b0);
        add_beat(32'h0000_0033, 4'h8, 1'b1);
        done_q.push_back(1'b0);
        do_init(32'h0000_3000, 8'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_awaddr_stable", 64'(bus.m_awaddr), 64'h3000);
        end
        check("t3_awvalid_held", 64'(bus.m_awvalid), 1);
        check("t3_accepts_stalled", 64'(next_cnt - base), 2);
        check("t3_next_low", 64'(bus.wDataNext), 0);
        aw_rdy = 1'b1;
        wait_done(3, "t3_done");
        check("t3_accepts_total", 64'(next_cnt - base), 4);

        // error response, back-to-back request in the wDone cycle
        b_resp = 2'b10;
        add_beat(32'hCAFEF00D, 4'hF, 1'b1);
        add_beat(32'h0BADC0DE, 4'hC, 1'b1);
        done_q.push_back(1'b1);
        do_init(32'h0000_4000, 8'd0);
        for (int i = 0; i < 50 && !bus.wDone; i++) tick();
        check("t4_wDone", 64'(bus.wDone), 1);
        check("t4_wErr", 64'(bus.wErr), 1);
        check("t4_ready_in_done", 64'(bus.writeReady), 1);
        b_resp = 2'b00;
        done_q.push_back(1'b0);
        do_init(32'h0000_5002, 8'd0);
        check("t4_next_accepted", 64'(bus.m_awvalid), 1);
        tick();
        check("t4_wDone_one_cycle", 64'(bus.wDone), 0);
        wait_done(5, "t4_done2");

        // ignored initWrite mid-burst, surplus beat refused
        w_mode = 2;
        base = next_cnt;
        add_beat(32'h0000_0011, 4'hF, 1'b0);
        add_beat(32'h0000_0022, 4'hF, 1'b1);
        beat_q.push_back({32'h0000_0033, 4'hF});
        done_q.push_back(1'b0);
        do_init(32'h0000_6000, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        bus.initWrite = 1'b1;
        bus.writeAddr = 32'h0000_7000;
        bus.writeLen  = 8'd5;
        tick();
        check("t5_ready_busy", 64'(bus.writeReady), 0);
        @(posedge clk); #1;
        bus.initWrite = 1'b0;
        tick();
        check("t5_awaddr_kept", 64'(bus.m_awaddr), 64'h6000);
        check("t5_awlen_kept", 64'(bus.m_awlen), 1);
        w_mode = 0;
        wait_done(6, "t5_done");
        repeat (6) tick();
        check("t5_single_done", 64'(done_cnt), 6);
        check("t5_next_pulses", 64'(next_cnt - base), 2);
        beat_q.delete();
        took = 1'b0;
        tick();

        // reset mid-burst
        w_mode = 2;
        base = next_cnt;
        for (int i = 0; i < 4; i++) beat_q.push_back({32'h0000_0080 + 32'(i), 4'hF});
        do_init(32'h0000_8000, 8'd3);
        for (int i = 0; i < 20 && (next_cnt - base) < 2; i++) tick();
        check("t6_pre_accepts", 64'(next_cnt - base), 2);
        rst = 1'b1;
        #1;
        check("t6_rst_awvalid", 64'(bus.m_awvalid), 0);
        check("t6_rst_wvalid", 64'(bus.m_wvalid), 0);
        check("t6_rst_bready", 64'(bus.m_bready), 0);
        check("t6_rst_wDone", 64'(bus.wDone), 0);
        check("t6_rst_wDataNext", 64'(bus.wDataNext), 0);
        beat_q.delete();
        took = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        w_mode = 0;
        tick();
        check("t6_ready_after", 64'(bus.writeReady), 1);
        check("t6_fifo_empty", 64'(bus.m_wvalid), 0);
        add_beat(32'hA5A5_5A5A, 4'h3, 1'b1);
        done_q.push_back(1'b0);
        do_init(32'h0000_9000, 8'd0);
        wait_done(7, "t6_done");

        repeat (4) tick();
        check("end_aw_q_empty", 64'(aw_q.size()), 0);
        check("end_w_q_empty", 64'(w_q.size()), 0);
        check("end_done_q_empty", 64'(done_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
